// File: rtl/sram_arb2.sv
//==============================================================================
// Module   : sram_arb2
// Purpose  : Two-port arbiter sharing one byte-enabled single-port sync SRAM.
//            Build option: SRAM_ARB_FIXED_PRI_EN (port 0 wins every contention).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sram_arb2 #(
  parameter  int W_DATA  = 32,
  parameter  int W_ADDR  = 11,
  localparam int N_BYTES = W_DATA / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_write,
  input  logic [W_ADDR-1:0]  req0_addr,
  input  logic [N_BYTES-1:0] req0_wmask,
  input  logic [W_DATA-1:0]  req0_wdata,
  output logic               rsp0_valid,
  output logic [W_DATA-1:0]  rsp0_rdata,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_write,
  input  logic [W_ADDR-1:0]  req1_addr,
  input  logic [N_BYTES-1:0] req1_wmask,
  input  logic [W_DATA-1:0]  req1_wdata,
  output logic               rsp1_valid,
  output logic [W_DATA-1:0]  rsp1_rdata,
  output logic [N_BYTES-1:0] sram_wen,
  output logic [W_ADDR-1:0]  sram_addr,
  output logic [W_DATA-1:0]  sram_wdata,
  input  logic [W_DATA-1:0]  sram_rdata
);

  logic               w_g0;
  logic               w_g1;
  logic               w_xfer;
  logic               w_write;
  logic [W_ADDR-1:0]  w_addr;
  logic [N_BYTES-1:0] w_wmask;
  logic [W_DATA-1:0]  w_wdata;
  logic               w_rsp0;
  logic               w_rsp1;

  logic [W_ADDR-1:0]  r_addr;
  logic [W_DATA-1:0]  r_wdata;
  logic               r_rd_pend;
  logic               r_rd_port;
  logic [W_DATA-1:0]  r_rdata0;
  logic [W_DATA-1:0]  r_rdata1;

`ifdef SRAM_ARB_FIXED_PRI_EN
  assign w_g0 = ~rst & req0_valid;
  assign w_g1 = ~rst & req1_valid & ~req0_valid;
`else
  // r_last holds the most recently granted port; the other one wins a tie.
  logic r_last;

  assign w_g0 = ~rst & req0_valid & (~req1_valid | r_last);
  assign w_g1 = ~rst & req1_valid & (~req0_valid | ~r_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_xfer) begin
      r_last <= w_g1;
    end
  end
`endif

  assign req0_ready = w_g0;
  assign req1_ready = w_g1;
  assign w_xfer     = w_g0 | w_g1;

  always_comb begin
    w_write = req0_write;
    w_addr  = req0_addr;
    w_wmask = req0_wmask;
    w_wdata = req0_wdata;
    if (w_g1) begin
      w_write = req1_write;
      w_addr  = req1_addr;
      w_wmask = req1_wmask;
      w_wdata = req1_wdata;
    end
  end

  // Address/data hold their last issued value while idle to avoid toggling.
  always_comb begin
    sram_wen   = '0;
    sram_addr  = r_addr;
    sram_wdata = r_wdata;
    if (w_xfer) begin
      sram_addr  = w_addr;
      sram_wdata = w_wdata;
      if (w_write) begin
        sram_wen = w_wmask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_pend <= 1'b0;
      r_rd_port <= 1'b0;
    end else begin
      r_rd_pend <= w_xfer & ~w_write;
      if (w_xfer) begin
        r_addr    <= w_addr;
        r_wdata   <= w_wdata;
        r_rd_port <= w_g1;
      end
    end
  end

  // Reset in the response cycle suppresses the pending response.
  assign w_rsp0 = r_rd_pend & ~r_rd_port & ~rst;
  assign w_rsp1 = r_rd_pend &  r_rd_port & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_rsp0) r_rdata0 <= sram_rdata;
      if (w_rsp1) r_rdata1 <= sram_rdata;
    end
  end

  assign rsp0_valid = w_rsp0;
  assign rsp1_valid = w_rsp1;
  assign rsp0_rdata = rst ? '0 : (w_rsp0 ? sram_rdata : r_rdata0);
  assign rsp1_rdata = rst ? '0 : (w_rsp1 ? sram_rdata : r_rdata1);

endmodule

`default_nettype wire

// File: tb/tb_sram_arb2.sv
//==============================================================================
// Module   : tb_sram_arb2
// Purpose  : Self-checking bench for sram_arb2 with a behavioural SRAM.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sram_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_write;
  logic [10:0] req0_addr;
  logic [3:0]  req0_wmask;
  logic [31:0] req0_wdata;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [10:0] req1_addr;
  logic [3:0]  req1_wmask;
  logic [31:0] req1_wdata;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic [3:0]  sram_wen;
  logic [10:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  always #5 clk = ~clk;

  sram_arb2 #(.W_DATA(32), .W_ADDR(11)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wmask(req0_wmask), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wmask(req1_wmask), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  // Single-port synchronous SRAM with byte enables.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (sram_wen[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
    sram_rdata <= mem[sram_addr];
  end

  // Reference model state.
  logic [31:0] ref_mem [0:2047];
  int          m_last;
  bit          m_pend;
  int          m_pport;
  logic [31:0] m_pdata;
  logic [31:0] m_hold [2];
  logic [10:0] m_haddr;
  logic [31:0] m_hwdata;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_pend  = 0;
    m_pport = 0;
    m_pdata = '0;
    m_hold[0] = '0;
    m_hold[1] = '0;
    m_haddr  = '0;
    m_hwdata = '0;
  endtask

  // One clock: check mid-cycle against the model, then advance the model at the edge.
  task automatic do_cycle(output bit g0, output bit g1, output logic ar0, output logic ar1);
    bit          ev;
    logic [31:0] ed;
    bit          wr;
    logic [10:0] a;
    logic [3:0]  m;
    logic [31:0] d;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      ev = m_pend && (m_pport == n) && !rst;
      ed = rst ? 32'h0 : (ev ? m_pdata : m_hold[n]);
      if (n == 0) begin
        chk("rsp0_valid", rsp0_valid, ev);
        chk("rsp0_rdata", rsp0_rdata, ed);
      end else begin
        chk("rsp1_valid", rsp1_valid, ev);
        chk("rsp1_rdata", rsp1_rdata, ed);
      end
    end
`ifdef SRAM_ARB_FIXED_PRI_EN
    g0 = !rst && req0_valid;
    g1 = !rst && req1_valid && !req0_valid;
`else
    if (!rst && req0_valid && req1_valid) begin
      g0 = (m_last == 1);
      g1 = (m_last == 0);
    end else begin
      g0 = !rst && req0_valid;
      g1 = !rst && req1_valid;
    end
`endif
    ar0 = req0_ready;
    ar1 = req1_ready;
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    wr = g1 ? req1_write : req0_write;
    a  = g1 ? req1_addr  : req0_addr;
    m  = g1 ? req1_wmask : req0_wmask;
    d  = g1 ? req1_wdata : req0_wdata;
    chk("sram_wen",   sram_wen,   ((g0 || g1) && wr) ? m : 4'h0);
    chk("sram_addr",  sram_addr,  (g0 || g1) ? a : m_haddr);
    chk("sram_wdata", sram_wdata, (g0 || g1) ? d : m_hwdata);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_pend) m_hold[m_pport] = m_pdata;
      m_pend = 0;
      if (g0 || g1) begin
        m_last   = g1 ? 1 : 0;
        m_haddr  = a;
        m_hwdata = d;
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end else begin
          m_pend  = 1;
          m_pport = g1 ? 1 : 0;
          m_pdata = ref_mem[a];
        end
      end
    end
    #1;
  endtask

  typedef struct {
    bit          v;
    bit          w;
    logic [10:0] a;
    logic [3:0]  m;
    logic [31:0] d;
  } req_t;

  typedef struct {
    req_t        p0;
    req_t        p1;
    logic [1:0]  rr;   // {ready1, ready0}, round robin build
    logic [1:0]  fp;   // {ready1, ready0}, fixed-priority build
    bit          x0v;  // rsp0 after the edge (round robin)
    logic [31:0] x0d;
    bit          x1v;
    logic [31:0] x1d;
  } vec_t;

  function automatic req_t RD(input logic [10:0] a);
    RD = '{1'b1, 1'b0, a, 4'h0, 32'h0};
  endfunction
  function automatic req_t WR(input logic [10:0] a, input logic [3:0] m, input logic [31:0] d);
    WR = '{1'b1, 1'b1, a, m, d};
  endfunction
  function automatic req_t NOP();
    NOP = '{1'b0, 1'b0, 11'h0, 4'h0, 32'h0};
  endfunction

  task automatic apply(input req_t p0, input req_t p1);
    req0_valid = p0.v; req0_write = p0.w; req0_addr = p0.a; req0_wmask = p0.m; req0_wdata = p0.d;
    req1_valid = p1.v; req1_write = p1.w; req1_addr = p1.a; req1_wmask = p1.m; req1_wdata = p1.d;
  endtask

  vec_t tbl[26];
  bit   g0, g1, busy0, busy1;
  logic ar0, ar1;
  logic [1:0] exp_r;
  req_t q0, q1;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    tbl[0]  = '{WR(11'h10, 4'hF, 32'hDEADBEEF), NOP(), 2'b01, 2'b01, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[1]  = '{RD(11'h10), NOP(), 2'b01, 2'b01, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[2]  = '{NOP(), NOP(), 2'b00, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[3]  = '{WR(11'h5, 4'hF, 32'h11223344), NOP(), 2'b01, 2'b01, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[4]  = '{WR(11'h5, 4'h5, 32'hAABBCCDD), NOP(), 2'b01, 2'b01, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[5]  = '{RD(11'h5), NOP(), 2'b01, 2'b01, 1'b1, 32'h11BB33DD, 1'b0, 32'h0};
    tbl[6]  = '{NOP(), NOP(), 2'b00, 2'b00, 1'b0, 32'h11BB33DD, 1'b0, 32'h0};
    tbl[7]  = '{WR(11'h1, 4'hF, 32'h11111111), WR(11'h2, 4'hF, 32'h22222222), 2'b10, 2'b01,
                1'b0, 32'h11BB33DD, 1'b0, 32'h0};
    tbl[8]  = '{WR(11'h1, 4'hF, 32'h11111111), NOP(), 2'b01, 2'b01, 1'b0, 32'h11BB33DD, 1'b0, 32'h0};
    tbl[9]  = '{RD(11'h1), RD(11'h2), 2'b10, 2'b01, 1'b0, 32'h11BB33DD, 1'b1, 32'h22222222};
    for (int i = 10; i < 17; i++) begin
      if (i % 2 == 0) tbl[i] = '{RD(11'h1), RD(11'h2), 2'b01, 2'b01, 1'b1, 32'h11111111, 1'b0, 32'h22222222};
      else            tbl[i] = '{RD(11'h1), RD(11'h2), 2'b10, 2'b01, 1'b0, 32'h11111111, 1'b1, 32'h22222222};
    end
    tbl[17] = '{NOP(), WR(11'h7, 4'hF, 32'hCAFEF00D), 2'b10, 2'b10, 1'b0, 32'h11111111, 1'b0, 32'h22222222};
    tbl[18] = '{RD(11'h7), NOP(), 2'b01, 2'b01, 1'b1, 32'hCAFEF00D, 1'b0, 32'h22222222};
    tbl[19] = '{NOP(), NOP(), 2'b00, 2'b00, 1'b0, 32'hCAFEF00D, 1'b0, 32'h22222222};
    tbl[20] = '{RD(11'h3), NOP(), 2'b01, 2'b01, 1'b1, 32'h0, 1'b0, 32'h22222222};
    for (int i = 21; i < 26; i++)
      tbl[i] = '{NOP(), NOP(), 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 32'h22222222};

    rst = 1'b1;
    apply(NOP(), NOP());
    @(posedge clk);
    #1;
    model_reset();
    do_cycle(g0, g1, ar0, ar1);
    chk("reset sram_addr", sram_addr, 11'h0);
    chk("reset rsp0_rdata", rsp0_rdata, 32'h0);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 26; i++) begin
      apply(tbl[i].p0, tbl[i].p1);
      do_cycle(g0, g1, ar0, ar1);
`ifdef SRAM_ARB_FIXED_PRI_EN
      exp_r = tbl[i].fp;
`else
      exp_r = tbl[i].rr;
      chk("vec rsp0_valid", rsp0_valid, tbl[i].x0v);
      chk("vec rsp0_rdata", rsp0_rdata, tbl[i].x0d);
      chk("vec rsp1_valid", rsp1_valid, tbl[i].x1v);
      chk("vec rsp1_rdata", rsp1_rdata, tbl[i].x1d);
`endif
      chk("vec ready", {ar1, ar0}, exp_r);
    end

    // Reset in the response cycle, then first contention after reset.
    apply(RD(11'h10), NOP());
    do_cycle(g0, g1, ar0, ar1);
    chk("rst-seq accept", ar0, 1'b1);
    rst = 1'b1;
    apply(RD(11'h1), RD(11'h2));
    do_cycle(g0, g1, ar0, ar1);
    chk("rst-seq ready under rst", {ar1, ar0}, 2'b00);
    chk("rst-seq rsp0_valid", rsp0_valid, 1'b0);
    chk("rst-seq rsp0_rdata", rsp0_rdata, 32'h0);
    chk("rst-seq rsp1_rdata", rsp1_rdata, 32'h0);
    rst = 1'b0;
    do_cycle(g0, g1, ar0, ar1);
    chk("post-rst contention ready", {ar1, ar0}, 2'b01);
    chk("post-rst rsp0_valid", rsp0_valid, 1'b1);
    chk("post-rst rsp1_valid", rsp1_valid, 1'b0);

    // Randomized traffic with requesters holding until accepted.
    busy0 = 0;
    busy1 = 0;
    q0 = NOP();
    q1 = NOP();
    for (int i = 0; i < 600; i++) begin
      if (!busy0) begin
        q0 = '{($urandom % 3) != 0, $urandom % 2 == 1, 11'($urandom % 16), 4'($urandom), $urandom};
        busy0 = q0.v;
      end
      if (!busy1) begin
        q1 = '{($urandom % 3) != 0, $urandom % 2 == 1, 11'($urandom % 16), 4'($urandom), $urandom};
        busy1 = q1.v;
      end
      rst = ($urandom % 50) == 0;
      apply(q0, q1);
      do_cycle(g0, g1, ar0, ar1);
      if (g0) begin busy0 = 0; q0 = NOP(); end
      if (g1) begin busy1 = 0; q1 = NOP(); end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
